// File: rtl/prog_arb_pkg.sv
// Shared types for the program-memory arbiter: FSM states, client ids and
// the round-robin helper that names the other client.
package prog_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    CLIENT_A,
    CLIENT_B
  } client_t;

  function automatic client_t other_client(input client_t c);
    return (c == CLIENT_A) ? CLIENT_B : CLIENT_A;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins; on a tie
// the client that was not granted last time wins.
module rr_pick2
  import prog_arb_pkg::*;
(
  input  logic    a_req_i,
  input  logic    b_req_i,
  input  client_t last_grant_i,
  output logic    any_o,
  output client_t winner_o
);

  always_comb begin
    any_o    = a_req_i | b_req_i;
    winner_o = CLIENT_A;
    if (a_req_i && b_req_i) begin
      winner_o = other_client(last_grant_i);
    end else if (b_req_i) begin
      winner_o = CLIENT_B;
    end
  end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares the program-memory read port between CPU fetch (A) and data reads (B),
// one read in flight. Optional WAIT timeout enabled by macro PROG_ARB_TIMEOUT_EN.
module prog_mem_arbiter
  import prog_arb_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              a_req_in,
  input  logic [ADDR_W-1:0] a_addr_in,
  output logic              a_valid_out,
  output logic [DATA_W-1:0] a_data_out,
  input  logic              b_req_in,
  input  logic [ADDR_W-1:0] b_addr_in,
  output logic              b_valid_out,
  output logic [DATA_W-1:0] b_data_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_valid_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              err_out
);

  arb_state_t        state_q, state_d;
  client_t           last_q, last_d;
  client_t           win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              a_vld_q, a_vld_d;
  logic              b_vld_q, b_vld_d;
  logic [DATA_W-1:0] a_data_q, a_data_d;
  logic [DATA_W-1:0] b_data_q, b_data_d;

  logic              pick_any;
  client_t           pick_win;

`ifdef PROG_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
`endif

  rr_pick2 u_pick (
    .a_req_i      (a_req_in),
    .b_req_i      (b_req_in),
    .last_grant_i (last_q),
    .any_o        (pick_any),
    .winner_o     (pick_win)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    win_d    = win_q;
    addr_d   = addr_q;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
    a_data_d = a_data_q;
    b_data_d = b_data_q;
`ifdef PROG_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          win_d   = pick_win;
          addr_d  = (pick_win == CLIENT_A) ? a_addr_in : b_addr_in;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef PROG_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mem_valid_in) begin
          if (win_q == CLIENT_A) begin
            a_data_d = mem_data_in;
            a_vld_d  = 1'b1;
          end else begin
            b_data_d = mem_data_in;
            b_vld_d  = 1'b1;
          end
          last_d  = win_q;
          state_d = IDLE;
        end
`ifdef PROG_ARB_TIMEOUT_EN
        // The TIMEOUT_CYC-th silent WAIT cycle aborts with zero data.
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          if (win_q == CLIENT_A) begin
            a_data_d = '0;
            a_vld_d  = 1'b1;
          end else begin
            b_data_d = '0;
            b_vld_d  = 1'b1;
          end
          err_d   = 1'b1;
          last_d  = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      last_q   <= CLIENT_B;
      win_q    <= CLIENT_A;
      addr_q   <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
`ifdef PROG_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      win_q    <= win_d;
      addr_q   <= addr_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
`ifdef PROG_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  assign mem_req_out  = (state_q == ISSUE);
  assign mem_addr_out = addr_q;
  assign a_valid_out  = a_vld_q;
  assign a_data_out   = a_data_q;
  assign b_valid_out  = b_vld_q;
  assign b_data_out   = b_data_q;
`ifdef PROG_ARB_TIMEOUT_EN
  assign err_out      = err_q;
`else
  assign err_out      = 1'b0;
`endif

endmodule
